fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer between the program counter and the synchronous instruction block RAM (1-cycle read latency). It owns the PC, drives the RAM enable and word address, captures each fetched word, and presents it to the decode/controller stage over a valid/ready handshake. It supports free-run and single-step modes, PC redirects for branch and jump, and a halt-instruction stop.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- HALT_INST, 32'hFFFF_FFFF, instruction word that stops fetching once accepted
- clk  in  1  system clock, the divided core clock
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- run  in  1  level; 1 = fetch continuously, 0 = step mode
- step  in  1  single-step request; a rising edge is detected internally
- redirect  in  1  one-cycle pulse that loads redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0
- mem_ce  out  1  RAM enable, high only in ISSUE
- mem_addr  out  30  RAM word address = pc[31:2]
- mem_dout  in  32  RAM read data, valid the cycle after ISSUE
- inst  out  32  captured instruction
- inst_pc  out  32  PC of the captured instruction
- inst_valid  out  1  inst/inst_pc are valid
- inst_ready  in  1  downstream accepts when inst_valid & inst_ready
- pc  out  32  current fetch PC
- halted  out  1  high in HALT
- fetch_count  out  16  number of accepted instructions, saturating

## Operation
- States: IDLE, ISSUE, WAIT, VALID, HALT.
- IDLE:
  - run=1 goes to ISSUE.
  - run=0 with a step rising edge (step=1 and the registered previous step=0) goes to ISSUE.
  - Otherwise stays in IDLE.
- ISSUE: mem_ce=1, mem_addr=pc[31:2]; always goes to WAIT.
- WAIT: inst<=mem_dout, inst_pc<=pc, inst_valid<=1; goes to VALID.
- VALID: holds inst, inst_pc and inst_valid stable until inst_valid & inst_ready. On accept:
  - pc<=pc+4; wraps 32'hFFFF_FFFC to 0.
  - fetch_count increments; holds at 16'hFFFF.
  - inst_valid<=0.
  - Next state: HALT if inst==HALT_INST; else ISSUE if run=1; else IDLE.
- HALT: halted=1, no RAM access. Only redirect or reset leaves HALT.
- Redirect, active in any state:
  - pc<={redirect_pc[31:2],2'b00}; inst_valid<=0.
  - Any in-flight read is discarded.
  - Next state is ISSUE if run=1, else IDLE.
  - Redirect takes priority over an accept in the same cycle: the instruction counts as accepted (fetch_count increments) but pc takes redirect_pc, not pc+4. A HALT_INST accepted together with a redirect does not halt.
- run dropping to 0 mid-fetch: the current fetch completes to VALID; after accept the FSM goes to IDLE.
- A step edge outside IDLE is ignored and not queued.

## Timing
- Reset (rst=0 at a clk edge), regardless of state, sets:
  - state=IDLE, pc=PC_RESET
  - inst=0, inst_pc=0, inst_valid=0
  - mem_ce=0, halted=0, fetch_count=0
  - previous-step register=0
- All outputs are registered or decoded from state; there is no combinational path from inst_ready to any output.
- Latency from ISSUE to inst_valid=1 is 2 cycles. With inst_ready held at 1, throughput is one instruction per 3 cycles.
- From a step edge in IDLE to inst_valid=1 is 3 cycles.
- After a redirect with run=1: ISSUE on the next cycle, and inst_valid for the new PC 3 cycles after the redirect cycle.

## Test plan
- Free-run: reset, run=1, inst_ready=1, RAM words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xFFFFFFFF.
  - Required: inst_pc 0x0, 0x4, 0x8, 0xC in order; then halted=1 and fetch_count=4.
  - Required: mem_ce stays 0 after halt.
- Backpressure: inst_ready=0 for 5 cycles while in VALID.
  - Required: inst/inst_pc stable, pc unchanged, no mem_ce pulses.
  - Required: accept on release, then pc advances by exactly 4.
- Single-step: run=0, step held high for 4 cycles.
  - Required: exactly one fetch (inst_pc=0x0); FSM returns to IDLE; pc=0x4.
  - Required: a second step pulse fetches 0x4.
- Redirect: redirect=1, redirect_pc=0x0000_0013 while in WAIT.
  - Required: captured data is discarded and inst_valid stays 0.
  - Required: the next inst_pc=0x0000_0010.
- Redirect + accept in the same cycle: redirect_pc=0x40.
  - Required: pc=0x40, fetch_count increments by 1.
- Redirect from HALT: redirect_pc=0x40.
  - Required: halted=0 and the next inst_pc=0x40.
- Wrap and reset: redirect_pc=0xFFFF_FFFC, accept one instruction.
  - Required: pc=0.
  - Required: rst=0 during WAIT gives IDLE, pc=PC_RESET and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues reads to a 1-cycle-latency
// instruction RAM, captures each word and hands it to decode over a
// valid/ready handshake. Supports free-run, single-step, redirect and halt.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   run, step           free-run level / single-step request (edge detected)
//   redirect,redirect_pc one-cycle PC redirect and its target
//   mem_ce, mem_addr    RAM enable and word address
//   mem_dout            RAM read data (valid the cycle after mem_ce)
//   inst, inst_pc,
//   inst_valid,
//   inst_ready          captured instruction handshake to decode
//   pc                  current fetch PC
//   halted              high while stopped on the halt instruction
//   fetch_count         accepted instructions, saturating
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_ce,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   pc_d, inst_d, inst_pc_d;
  logic              inst_valid_d;
  logic [CW-1:0]     count_d;
  logic              step_q;
  logic              step_edge;
  logic              accept;

  assign step_edge = step & ~step_q;
  assign accept    = (state == VALID) & inst_valid & inst_ready;
  assign mem_addr  = pc[31:2];

  // Next-state and next-value logic; redirect overrides everything last.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    count_d      = fetch_count;

    unique case (state)
      IDLE: begin
        if (run || step_edge) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        inst_d       = mem_dout;
        inst_pc_d    = pc;
        inst_valid_d = 1'b1;
        state_d      = VALID;
      end
      VALID: begin
        if (accept) begin
          pc_d         = pc + XLEN'(4);
          inst_valid_d = 1'b0;
          if (fetch_count != {CW{1'b1}}) count_d = fetch_count + CW'(1);
          if (inst == HALT_INST) state_d = HALT;
          else if (run)          state_d = ISSUE;
          else                   state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect drops any in-flight or captured word but keeps the accept count.
    if (redirect) begin
      pc_d         = redirect_pc & ~XLEN'(3);
      inst_d       = inst;
      inst_pc_d    = inst_pc;
      inst_valid_d = 1'b0;
      state_d      = run ? ISSUE : IDLE;
    end
  end

  // State and output registers; mem_ce/halted are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      inst        <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      mem_ce      <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
      step_q      <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      inst        <= inst_d;
      inst_pc     <= inst_pc_d;
      inst_valid  <= inst_valid_d;
      mem_ce      <= (state_d == ISSUE);
      halted      <= (state_d == HALT);
      fetch_count <= count_d;
      step_q      <= step;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, run, step, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic        mem_ce;
  logic [29:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] inst, inst_pc, pc;
  logic        inst_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] ram [256];
  int checks = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc(pc), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ce) mem_dout <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; step = 1'b0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance negedges until inst_valid, bounded; n = negedges waited.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) check(tag, 32'd0, 32'd1);
  endtask

  int n, c0, acc;
  logic [31:0] s_inst, s_ipc, s_pc;
  logic ce_seen;
  logic [31:0] pcs[$];
  int ts[$];

  // Transaction-level reference state for the random phase.
  logic [31:0] exp_pc;
  int          exp_count;
  logic        exp_halted;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0000_0013 + 32'(i);
    ram[0] = 32'h2008_0005; ram[1] = 32'h2009_0003;
    ram[2] = 32'h0109_5020; ram[3] = HALT_W;

    // Reset values.
    do_reset();
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_ce", 32'(mem_ce), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);

    // Free-run to halt.
    run = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 100 && !halted; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        check("free_inst", inst, ram[inst_pc[9:2]]);
        pcs.push_back(inst_pc);
        ts.push_back(i);
      end
    end
    check("free_halted", 32'(halted), 32'd1);
    check("free_n", 32'(pcs.size()), 32'd4);
    for (int i = 0; i < pcs.size(); i++) check("free_pc", pcs[i], 32'(4 * i));
    for (int i = 1; i < ts.size(); i++) check("free_gap", 32'(ts[i] - ts[i-1]), 32'd3);
    check("free_count", 32'(fetch_count), 32'd4);
    ce_seen = 1'b0;
    repeat (10) begin @(negedge clk); ce_seen |= mem_ce; end
    check("free_ce_after_halt", 32'(ce_seen), 32'd0);

    // Backpressure.
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    wait_valid("bp_timeout", n);
    s_inst = inst; s_ipc = inst_pc; s_pc = pc; ce_seen = 1'b0;
    repeat (5) begin @(negedge clk); ce_seen |= mem_ce; end
    check("bp_inst", inst, s_inst);
    check("bp_ipc", inst_pc, s_ipc);
    check("bp_pc", pc, s_pc);
    check("bp_ce", 32'(ce_seen), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_pc", pc, s_pc + 32'd4);
    check("bp_accept_count", 32'(fetch_count), 32'd1);

    // Single step: step held 4 cycles gives one fetch.
    do_reset();
    inst_ready = 1'b1; step = 1'b1;
    acc = 0; n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 4) step = 1'b0;
      if (inst_valid) begin
        acc++;
        if (n == 0) n = i;
        check("step_ipc", inst_pc, 32'h0);
      end
    end
    check("step_accepts", 32'(acc), 32'd1);
    check("step_latency", 32'(n), 32'd3);
    check("step_pc", pc, 32'h4);
    check("step_idle_ce", 32'(mem_ce), 32'd0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_valid("step2_timeout", n);
    check("step2_ipc", inst_pc, 32'h4);
    check("step2_latency", 32'(n + 1), 32'd3);

    // Redirect during WAIT.
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    n = 0;
    while (!mem_ce && n < 20) begin @(negedge clk); n++; end
    check("rd_saw_issue", 32'(mem_ce), 32'd1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0013;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_valid_dropped", 32'(inst_valid), 32'd0);
    check("rd_pc", pc, 32'h10);
    inst_ready = 1'b0;
    wait_valid("rd_timeout", n);
    check("rd_latency", 32'(n + 1), 32'd3);
    check("rd_ipc", inst_pc, 32'h10);
    check("rd_inst", inst, ram[4]);

    // Redirect with accept in the same cycle.
    c0 = 32'(fetch_count);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    ram[16] = HALT_W;
    @(negedge clk);
    redirect = 1'b0;
    check("rda_pc", pc, 32'h40);
    check("rda_count", 32'(fetch_count), 32'(c0 + 1));

    // Run into HALT at 0x40, then leave it with a redirect.
    n = 0;
    while (!halted && n < 30) begin @(negedge clk); n++; end
    check("h_halted", 32'(halted), 32'd1);
    check("h_pc", pc, 32'h44);
    ram[16] = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    check("h_unhalt", 32'(halted), 32'd0);
    wait_valid("h_timeout", n);
    check("h_ipc", inst_pc, 32'h40);
    check("h_inst", inst, 32'h1234_5678);

    // HALT_INST accepted together with a redirect does not halt.
    ram[32] = HALT_W;
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b0;
    wait_valid("hr_timeout", n);
    check("hr_ipc", inst_pc, 32'h80);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b0;
    check("hr_no_halt", 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    check("hr_no_halt_later", 32'(halted), 32'd0);

    // Wrap: accept at 0xFFFF_FFFC gives pc 0.
    wait_valid("wrap_timeout", n);
    check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    @(negedge clk);
    check("wrap_pc", pc, 32'h0);

    // Reset during WAIT.
    n = 0;
    while (!mem_ce && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    check("wr_pc", pc, 32'h0);
    check("wr_valid", 32'(inst_valid), 32'd0);
    check("wr_inst", inst, 32'h0);
    check("wr_ipc", inst_pc, 32'h0);
    check("wr_ce", 32'(mem_ce), 32'd0);
    check("wr_count", 32'(fetch_count), 32'd0);
    @(negedge clk);
    check("wr_idle_ce", 32'(mem_ce), 32'd0);

    // Random phase against a transaction-level model.
    for (int i = 0; i < 256; i++)
      ram[i] = ($urandom_range(0, 15) == 0) ? HALT_W : $urandom;
    do_reset();
    @(negedge clk);
    exp_pc = 32'h0; exp_count = 0; exp_halted = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_pc", pc, exp_pc);
      check("rnd_count", 32'(fetch_count), 32'(exp_count));
      check("rnd_halted", 32'(halted), 32'(exp_halted));
      if (inst_valid) begin
        check("rnd_ipc", inst_pc, exp_pc);
        check("rnd_inst", inst, ram[exp_pc[9:2]]);
      end
      if (mem_ce && (inst_valid || halted)) check("rnd_ce_illegal", 32'd1, 32'd0);
      run         = ($urandom_range(0, 9) != 0);
      step        = 1'($urandom_range(0, 1));
      inst_ready  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      if (inst_valid && inst_ready) begin
        if (exp_count < 16'hFFFF) exp_count++;
        if (!redirect) begin
          if (ram[exp_pc[9:2]] == HALT_W) exp_halted = 1'b1;
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'd3;
        exp_halted = 1'b0;
      end
      @(negedge clk);
    end
    check("rnd_progress", 32'(exp_count >= 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
